issue_scheduler: RTL and testbench

//   Issue queue and sequencer for the single shared execute unit. Holds up to
//   NUM_ENTRY renamed instructions, wakes sources on writeback broadcasts,

---
 rtl/issue_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Age-ordered, compacting issue queue for the single shared execute unit.
// Wakes sources on writeback, issues the oldest ready entry, and blocks issue during a multi-cycle MUL.
`ifndef INST_SIZE_LOG
`define INST_SIZE_LOG 3
`endif
`ifndef INST_OP_ADD
`define INST_OP_ADD 3'd0
`endif
`ifndef INST_OP_LI
`define INST_OP_LI 3'd1
`endif
`ifndef INST_OP_LD
`define INST_OP_LD 3'd2
`endif
`ifndef INST_OP_BR
`define INST_OP_BR 3'd3
`endif
`ifndef INST_OP_MUL
`define INST_OP_MUL 3'd4
`endif

module issue_scheduler #(
  parameter int NUM_ENTRY = 4,
  parameter int TAG_LEN   = 3,
  parameter int MUL_LAT   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [TAG_LEN-1:0]        enq_tag,
  input  logic [`INST_SIZE_LOG-1:0] enq_op,
  input  logic                      enq_rs1_rdy,
  input  logic [TAG_LEN-1:0]        enq_rs1_tag,
  input  logic                      enq_rs2_rdy,
  input  logic [TAG_LEN-1:0]        enq_rs2_tag,
  input  logic                      wb_valid,
  input  logic [TAG_LEN-1:0]        wb_tag,
  input  logic                      flush,
  output logic                      iss_valid,
  output logic [TAG_LEN-1:0]        iss_tag,
  output logic [`INST_SIZE_LOG-1:0] iss_op,
  output logic                      done_valid,
  output logic [TAG_LEN-1:0]        done_tag
);

  localparam int IDX_W  = $clog2(NUM_ENTRY);
  localparam int CNT_W  = $clog2(NUM_ENTRY + 1);
  localparam int BUSY_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  typedef struct packed {
    logic                      valid;
    logic [TAG_LEN-1:0]        tag;
    logic [`INST_SIZE_LOG-1:0] op;
    logic                      rs1_rdy;
    logic [TAG_LEN-1:0]        rs1_tag;
    logic                      rs2_rdy;
    logic [TAG_LEN-1:0]        rs2_tag;
  } entry_t;

  entry_t              ent_q [NUM_ENTRY];
  entry_t              ent_d [NUM_ENTRY];
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BUSY_W-1:0]   busy_q, busy_d;
  logic [TAG_LEN-1:0]  mul_tag_q, mul_tag_d;
  logic                done_valid_q, done_valid_d;
  logic [TAG_LEN-1:0]  done_tag_q, done_tag_d;

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [0:0]          unit_state;
  logic                issue;
  logic                sel_is_mul;
  logic                enq_fire;
  logic [CNT_W-1:0]    enq_slot;
  entry_t              enq_entry;

  assign unit_state = (busy_q == '0) ? ST_IDLE : ST_MUL_BUSY;
  assign enq_ready  = (count_q < CNT_W'(NUM_ENTRY));
  assign enq_fire   = enq_valid & enq_ready;

  // Oldest-first select: lowest slot index whose sources are both ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue      = sel_found & (unit_state == ST_IDLE) & ~flush;
  assign sel_is_mul = (ent_q[sel_idx].op == `INST_OP_MUL);
  assign iss_valid  = issue;
  assign iss_tag    = issue ? ent_q[sel_idx].tag : '0;
  assign iss_op     = issue ? ent_q[sel_idx].op  : '0;

  // A source broadcast in the enqueue cycle would otherwise be missed forever.
  always_comb begin
    enq_entry         = '0;
    enq_entry.valid   = 1'b1;
    enq_entry.tag     = enq_tag;
    enq_entry.op      = enq_op;
    enq_entry.rs1_tag = enq_rs1_tag;
    enq_entry.rs2_tag = enq_rs2_tag;
    enq_entry.rs1_rdy = enq_rs1_rdy | (wb_valid & (wb_tag == enq_rs1_tag));
    enq_entry.rs2_rdy = enq_rs2_rdy | (wb_valid & (wb_tag == enq_rs2_tag));
  end

  assign enq_slot = count_q - CNT_W'(issue);

  // Queue next state: compact over the issued slot, wake up, then append.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      ent_d[i] = ent_q[i];
    end
    if (issue) begin
      for (int i = 0; i < NUM_ENTRY - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          ent_d[i] = ent_q[i+1];
        end
      end
      ent_d[NUM_ENTRY-1] = '0;
    end
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (wb_valid && ent_d[i].valid) begin
        if (ent_d[i].rs1_tag == wb_tag) ent_d[i].rs1_rdy = 1'b1;
        if (ent_d[i].rs2_tag == wb_tag) ent_d[i].rs2_rdy = 1'b1;
      end
    end
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (enq_fire && (CNT_W'(i) == enq_slot)) begin
        ent_d[i] = enq_entry;
      end
    end
    count_d = count_q - CNT_W'(issue) + CNT_W'(enq_fire);
    if (flush) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        ent_d[i] = '0;
      end
      count_d = '0;
    end
  end

  // Execute-unit sequencing; issue only happens with busy_q == 0, so the
  // MUL completion and a new 1-cycle completion can never coincide.
  always_comb begin
    busy_d       = busy_q;
    mul_tag_d    = mul_tag_q;
    done_valid_d = 1'b0;
    done_tag_d   = done_tag_q;
    if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
      if (busy_q == BUSY_W'(1)) begin
        done_valid_d = 1'b1;
        done_tag_d   = mul_tag_q;
      end
    end
    if (issue) begin
      if (sel_is_mul && (MUL_LAT > 1)) begin
        busy_d    = BUSY_W'(MUL_LAT - 1);
        mul_tag_d = iss_tag;
      end else begin
        done_valid_d = 1'b1;
        done_tag_d   = iss_tag;
      end
    end
    if (flush) begin
      busy_d       = '0;
      done_valid_d = 1'b0;
      done_tag_d   = done_tag_q;
    end
  end

  // NOTE: state registers use non-blocking assignments only; the queue is
  // reset too, because stale valid bits would otherwise issue after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        ent_q[i] <= '0;
      end
      count_q      <= '0;
      busy_q       <= '0;
      mul_tag_q    <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q      <= count_d;
      busy_q       <= busy_d;
      mul_tag_q    <= mul_tag_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
    end
  end

  assign done_valid = done_valid_q;
  assign done_tag   = done_tag_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: issue latency, MUL blocking, wakeup,
// out-of-order select in a full queue, flush and asynchronous reset mid-MUL.
`ifndef INST_SIZE_LOG
`define INST_SIZE_LOG 3
`endif
`ifndef INST_OP_ADD
`define INST_OP_ADD 3'd0
`endif
`ifndef INST_OP_MUL
`define INST_OP_MUL 3'd4
`endif

module tb_issue_scheduler;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      enq_valid;
  logic                      enq_ready;
  logic [2:0]                enq_tag;
  logic [`INST_SIZE_LOG-1:0] enq_op;
  logic                      enq_rs1_rdy;
  logic [2:0]                enq_rs1_tag;
  logic                      enq_rs2_rdy;
  logic [2:0]                enq_rs2_tag;
  logic                      wb_valid;
  logic [2:0]                wb_tag;
  logic                      flush;
  logic                      iss_valid;
  logic [2:0]                iss_tag;
  logic [`INST_SIZE_LOG-1:0] iss_op;
  logic                      done_valid;
  logic [2:0]                done_tag;

  int checks   = 0;
  int failures = 0;

  issue_scheduler #(.NUM_ENTRY(4), .TAG_LEN(3), .MUL_LAT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_tag     (enq_tag),
    .enq_op      (enq_op),
    .enq_rs1_rdy (enq_rs1_rdy),
    .enq_rs1_tag (enq_rs1_tag),
    .enq_rs2_rdy (enq_rs2_rdy),
    .enq_rs2_tag (enq_rs2_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .flush       (flush),
    .iss_valid   (iss_valid),
    .iss_tag     (iss_tag),
    .iss_op      (iss_op),
    .done_valid  (done_valid),
    .done_tag    (done_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    enq_valid = 1'b0; enq_tag = '0; enq_op = '0;
    enq_rs1_rdy = 1'b0; enq_rs1_tag = '0;
    enq_rs2_rdy = 1'b0; enq_rs2_tag = '0;
    wb_valid = 1'b0; wb_tag = '0; flush = 1'b0;
  endtask

  // Advance one cycle: inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic enq(input logic [2:0] tag, input logic [2:0] op,
                     input logic r1, input logic [2:0] t1,
                     input logic r2, input logic [2:0] t2);
    enq_valid = 1'b1; enq_tag = tag; enq_op = op;
    enq_rs1_rdy = r1; enq_rs1_tag = t1;
    enq_rs2_rdy = r2; enq_rs2_tag = t2;
  endtask

  task automatic wb(input logic [2:0] tag);
    wb_valid = 1'b1; wb_tag = tag;
  endtask

  task automatic expect_iss(input string tag, input logic v, input logic [2:0] t, input logic [2:0] op);
    check({tag, ".iss_valid"}, iss_valid, v);
    check({tag, ".iss_tag"},   iss_tag,   t);
    check({tag, ".iss_op"},    iss_op,    op);
  endtask

  task automatic expect_done(input string tag, input logic v, input logic [2:0] t);
    check({tag, ".done_valid"}, done_valid, v);
    if (v) check({tag, ".done_tag"}, done_tag, t);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    check("rst.enq_ready",  enq_ready,  1);
    check("rst.iss_valid",  iss_valid,  0);
    check("rst.done_valid", done_valid, 0);
    check("rst.done_tag",   done_tag,   0);
    cyc();
    rst = 1'b0;

    // ADD tag 2, both ready: issue next cycle, done one cycle later.
    cyc();
    enq(3'd2, `INST_OP_ADD, 1, 0, 1, 0);
    #1;
    expect_iss("add.enq", 0, 0, 0);
    cyc(); #1;
    expect_iss("add.iss", 1, 3'd2, `INST_OP_ADD);
    expect_done("add.iss", 0, 0);
    cyc(); #1;
    expect_done("add.done", 1, 3'd2);
    expect_iss("add.after", 0, 0, 0);
    cyc(); #1;
    check("add.done_drop", done_valid, 0);
    check("add.done_tag_held", done_tag, 3'd2);

    // MUL tag 1 then ADD tag 3: ADD waits until the MUL completion cycle.
    cyc();
    enq(3'd1, `INST_OP_MUL, 1, 0, 1, 0);
    cyc();
    enq(3'd3, `INST_OP_ADD, 1, 0, 1, 0);
    #1;
    expect_iss("mul.t0", 1, 3'd1, `INST_OP_MUL);
    cyc(); #1;
    expect_iss("mul.t1", 0, 0, 0);
    expect_done("mul.t1", 0, 0);
    cyc(); #1;
    expect_iss("mul.t2", 0, 0, 0);
    expect_done("mul.t2", 0, 0);
    cyc(); #1;
    expect_done("mul.t3", 1, 3'd1);
    expect_iss("mul.t3", 1, 3'd3, `INST_OP_ADD);
    cyc(); #1;
    expect_done("mul.t4", 1, 3'd3);
    expect_iss("mul.t4", 0, 0, 0);

    // Wakeup in the enqueue cycle: selectable the next cycle.
    cyc();
    enq(3'd4, `INST_OP_ADD, 0, 3'd1, 1, 0);
    wb(3'd1);
    cyc(); #1;
    expect_iss("wk0.iss", 1, 3'd4, `INST_OP_ADD);
    cyc(); #1;
    expect_done("wk0.done", 1, 3'd4);

    // Wakeup one cycle after enqueue: issue two cycles after enqueue.
    cyc();
    enq(3'd5, `INST_OP_ADD, 0, 3'd1, 1, 0);
    cyc();
    wb(3'd1);
    #1;
    expect_iss("wk1.wait", 0, 0, 0);
    cyc(); #1;
    expect_iss("wk1.iss", 1, 3'd5, `INST_OP_ADD);
    cyc(); #1;
    expect_done("wk1.done", 1, 3'd5);

    // Fill the queue with waiting entries; producers 5,6,7,4 for tags 0..3.
    cyc();
    #1;
    check("fill.ready_empty", enq_ready, 1);
    enq(3'd0, `INST_OP_ADD, 0, 3'd5, 1, 0);
    cyc(); enq(3'd1, `INST_OP_ADD, 0, 3'd6, 1, 0);
    cyc(); enq(3'd2, `INST_OP_ADD, 1, 0, 0, 3'd7);
    cyc(); enq(3'd3, `INST_OP_ADD, 0, 3'd4, 1, 0);
    cyc();
    enq(3'd6, `INST_OP_ADD, 1, 0, 1, 0);
    wb(3'd7);
    #1;
    check("fill.ready_full", enq_ready, 0);
    expect_iss("fill.none_ready", 0, 0, 0);
    cyc(); #1;
    expect_iss("fill.e2_first", 1, 3'd2, `INST_OP_ADD);
    check("fill.ready_same_cycle", enq_ready, 0);
    cyc();
    wb(3'd4);
    #1;
    check("fill.ready_after", enq_ready, 1);
    expect_iss("fill.gap", 0, 0, 0);
    expect_done("fill.done2", 1, 3'd2);
    cyc();
    wb(3'd5);
    #1;
    expect_iss("fill.e3", 1, 3'd3, `INST_OP_ADD);
    cyc();
    wb(3'd6);
    #1;
    expect_iss("fill.e0", 1, 3'd0, `INST_OP_ADD);
    expect_done("fill.done3", 1, 3'd3);
    cyc(); #1;
    expect_iss("fill.e1", 1, 3'd1, `INST_OP_ADD);
    expect_done("fill.done0", 1, 3'd0);
    cyc(); #1;
    expect_iss("fill.empty", 0, 0, 0);
    expect_done("fill.done1", 1, 3'd1);
    check("fill.ready_end", enq_ready, 1);

    // Flush with a full queue and a MUL in flight.
    cyc(); enq(3'd0, `INST_OP_ADD, 0, 3'd5, 1, 0);
    cyc(); enq(3'd1, `INST_OP_ADD, 0, 3'd5, 1, 0);
    cyc(); enq(3'd2, `INST_OP_ADD, 0, 3'd5, 1, 0);
    cyc(); enq(3'd7, `INST_OP_MUL, 1, 0, 1, 0);
    cyc(); #1;
    expect_iss("fl.mul", 1, 3'd7, `INST_OP_MUL);
    check("fl.ready_full4", enq_ready, 0);
    cyc();
    enq(3'd3, `INST_OP_ADD, 0, 3'd5, 1, 0);
    #1;
    check("fl.ready_slot", enq_ready, 1);
    expect_iss("fl.busy1", 0, 0, 0);
    cyc();
    flush = 1'b1;
    #1;
    check("fl.ready_full", enq_ready, 0);
    expect_iss("fl.flush_cycle", 0, 0, 0);
    cyc();
    wb(3'd5);
    #1;
    check("fl.ready_cleared", enq_ready, 1);
    expect_iss("fl.after", 0, 0, 0);
    check("fl.no_mul_done", done_valid, 0);
    cyc(); #1;
    expect_iss("fl.empty", 0, 0, 0);
    check("fl.no_done2", done_valid, 0);
    cyc(); #1;
    check("fl.no_done3", done_valid, 0);

    // Asynchronous reset while the MUL counter sits at 1.
    cyc(); enq(3'd6, `INST_OP_MUL, 1, 0, 1, 0);
    cyc();
    enq(3'd2, `INST_OP_ADD, 1, 0, 1, 0);
    #1;
    expect_iss("rm.mul", 1, 3'd6, `INST_OP_MUL);
    cyc(); #1;
    expect_iss("rm.busy2", 0, 0, 0);
    cyc(); #1;
    expect_iss("rm.busy1", 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rm.done_valid", done_valid, 0);
    check("rm.done_tag",   done_tag,   0);
    check("rm.iss_valid",  iss_valid,  0);
    check("rm.enq_ready",  enq_ready,  1);
    cyc();
    rst = 1'b0;
    #1;
    check("rm.post0_done", done_valid, 0);
    expect_iss("rm.post0", 0, 0, 0);
    cyc(); #1;
    check("rm.post1_done", done_valid, 0);
    expect_iss("rm.post1", 0, 0, 0);
    cyc(); #1;
    check("rm.post2_done", done_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
